game_control: RTL and testbench

Top-level game sequencer for the Breakout datapath. It owns lives, score and the remaining-brick count, and steps the game through idle, serve, play, life-lost pause, game-over and win. It gates the paddle (bar) and ball movers through enable outputs. It sits between the pushbutton inputs, the ball/brick collision logic and the VGA overlay that displays score and lives.

---
 rtl/game_control.sv | 217 +++++++++++++++++++++
 tb/tb_game_control.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control.sv
// ----------------------------------------------------------------------------
// game_control
//   Top-level sequencer for the Breakout game. Owns lives, score and the
//   remaining-brick count. Walks the game through IDLE, SERVE, PLAY, LOST,
//   GAME_OVER and WIN. Gates the bar and ball movers through enable outputs.
//
// Ports
//   clock        in   system (pixel) clock
//   reset        in   asynchronous reset, active-low
//   start        in   raw pushbutton, active-low, asynchronous to clock
//   frame_tick   in   one-cycle pulse per video frame
//   ball_lost    in   one-cycle pulse: ball left through the bottom edge
//   brick_hit    in   one-cycle pulse: one brick destroyed
//   state        out  IDLE=0 SERVE=1 PLAY=2 LOST=3 GAME_OVER=4 WIN=5
//   ball_hold    out  ball pinned above the bar centre
//   ball_run     out  ball motion enabled
//   bar_run      out  bar motion enabled
//   lives        out  remaining lives
//   score        out  accumulated score (saturating)
//   bricks_left  out  bricks still standing
//   game_over    out  high while in GAME_OVER
//   win          out  high while in WIN
// ----------------------------------------------------------------------------
module game_control #(
    parameter int LIVES        = 3,
    parameter int N_BRICKS     = 40,
    parameter int LOST_FRAMES  = 60,
    parameter int SCORE_W      = 10,
    parameter int BRICK_POINTS = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               ball_lost,
    input  logic               brick_hit,
    output logic [2:0]         state,
    output logic               ball_hold,
    output logic               ball_run,
    output logic               bar_run,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         bricks_left,
    output logic               game_over,
    output logic               win
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_LOST      = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_start_meta;
    logic                 r_start_sync;
    logic                 r_start_prev;
    logic                 w_start_evt;

    logic [1:0]           r_lives;
    logic [1:0]           w_lives_nxt;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [7:0]           r_bricks;
    logic [7:0]           w_bricks_nxt;
    logic [7:0]           r_frames;
    logic [7:0]           w_frames_nxt;

    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_sat;

    // Press edge of the synchronised button: released (1) last cycle,
    // pressed (0) now. Holding the button yields a single event.
    assign w_start_evt = r_start_prev & ~r_start_sync;

    // One extra bit catches the carry so the add can saturate instead of wrap.
    assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(BRICK_POINTS);
    assign w_score_sat = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters and the start synchroniser; sync flops rest at 1 (released).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start_meta <= 1'b1;
            r_start_sync <= 1'b1;
            r_start_prev <= 1'b1;
            r_lives      <= 2'(LIVES);
            r_score      <= '0;
            r_bricks     <= 8'(N_BRICKS);
            r_frames     <= '0;
        end else begin
            r_start_meta <= start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_bricks     <= w_bricks_nxt;
            r_frames     <= w_frames_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_lives_nxt  = r_lives;
        w_score_nxt  = r_score;
        w_bricks_nxt = r_bricks;
        w_frames_nxt = r_frames;

        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_nxt  = ST_SERVE;
                    w_lives_nxt  = 2'(LIVES);
                    w_score_nxt  = '0;
                    w_bricks_nxt = 8'(N_BRICKS);
                end
            end

            ST_SERVE: begin
                if (w_start_evt) begin
                    w_state_nxt = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (brick_hit) begin
                    w_score_nxt  = w_score_sat;
                    w_bricks_nxt = r_bricks - 8'd1;
                end
                if (ball_lost) begin
                    w_lives_nxt = r_lives - 2'd1;
                    if (r_lives == 2'd1) begin
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_state_nxt  = ST_LOST;
                        w_frames_nxt = '0;
                    end
                end
                // Clearing the last brick wins even if the ball fell the same cycle.
                if (brick_hit && (r_bricks == 8'd1)) begin
                    w_state_nxt = ST_WIN;
                end
            end

            ST_LOST: begin
                if (frame_tick) begin
                    if (r_frames == 8'(LOST_FRAMES - 1)) begin
                        w_state_nxt = ST_SERVE;
                    end else begin
                        w_frames_nxt = r_frames + 8'd1;
                    end
                end
            end

            ST_GAME_OVER, ST_WIN: begin
                // Counters stay frozen for the overlay until the next serve.
                if (w_start_evt) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status decode of the state register.
    always_comb begin
        ball_hold = 1'b1;
        ball_run  = 1'b0;
        bar_run   = 1'b0;
        game_over = 1'b0;
        win       = 1'b0;
        case (r_state)
            ST_SERVE: begin
                bar_run = 1'b1;
            end
            ST_PLAY: begin
                ball_hold = 1'b0;
                ball_run  = 1'b1;
                bar_run   = 1'b1;
            end
            ST_GAME_OVER: begin
                game_over = 1'b1;
            end
            ST_WIN: begin
                win = 1'b1;
            end
            default: begin
                ball_hold = 1'b1;
            end
        endcase
    end

    assign state       = r_state;
    assign lives       = r_lives;
    assign score       = r_score;
    assign bricks_left = r_bricks;

endmodule

// File: tb/tb_game_control.sv
// ----------------------------------------------------------------------------
// tb_game_control
//   Directed bench for game_control. A rule-level model of the game runs
//   alongside the DUT; a compare process checks every output on each falling
//   edge, and literal checks pin key points of the scenario.
//   Score is set up so a game can reach saturation (8 bits, 7 points/brick).
// ----------------------------------------------------------------------------
module tb_game_control;

    localparam int LIVES        = 3;
    localparam int N_BRICKS     = 40;
    localparam int LOST_FRAMES  = 60;
    localparam int SCORE_W      = 8;
    localparam int BRICK_POINTS = 7;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_LOST  = 3;
    localparam int S_OVER  = 4;
    localparam int S_WIN   = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b1;
    logic               frame_tick = 1'b0;
    logic               ball_lost = 1'b0;
    logic               brick_hit = 1'b0;
    logic [2:0]         state;
    logic               ball_hold;
    logic               ball_run;
    logic               bar_run;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [7:0]         bricks_left;
    logic               game_over;
    logic               win;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Rule-level model.
    int       m_state  = S_IDLE;
    int       m_lives  = LIVES;
    int       m_score  = 0;
    int       m_bricks = N_BRICKS;
    int       m_ticks  = 0;
    bit [2:0] m_hist   = 3'b111;  // start samples at edges n-1, n-2, n-3

    game_control #(
        .LIVES       (LIVES),
        .N_BRICKS    (N_BRICKS),
        .LOST_FRAMES (LOST_FRAMES),
        .SCORE_W     (SCORE_W),
        .BRICK_POINTS(BRICK_POINTS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .ball_lost  (ball_lost),
        .brick_hit  (brick_hit),
        .state      (state),
        .ball_hold  (ball_hold),
        .ball_run   (ball_run),
        .bar_run    (bar_run),
        .lives      (lives),
        .score      (score),
        .bricks_left(bricks_left),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // A press is seen two edges after the first edge that samples it low.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_state  = S_IDLE;
            m_lives  = LIVES;
            m_score  = 0;
            m_bricks = N_BRICKS;
            m_ticks  = 0;
            m_hist   = 3'b111;
        end else begin
            bit evt;
            int old_bricks;
            int old_lives;
            evt = !m_hist[1] && m_hist[2];
            m_hist = {m_hist[1:0], start};
            case (m_state)
                S_IDLE: if (evt) begin
                    m_state  = S_SERVE;
                    m_lives  = LIVES;
                    m_score  = 0;
                    m_bricks = N_BRICKS;
                end
                S_SERVE: if (evt) m_state = S_PLAY;
                S_PLAY: begin
                    old_bricks = m_bricks;
                    old_lives  = m_lives;
                    if (brick_hit) begin
                        m_score  = (m_score + BRICK_POINTS > SCORE_MAX) ? SCORE_MAX
                                                                        : m_score + BRICK_POINTS;
                        m_bricks = m_bricks - 1;
                    end
                    if (ball_lost) begin
                        m_lives = m_lives - 1;
                        m_ticks = 0;
                    end
                    if (brick_hit && old_bricks == 1) m_state = S_WIN;
                    else if (ball_lost) m_state = (old_lives == 1) ? S_OVER : S_LOST;
                end
                S_LOST: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == LOST_FRAMES) m_state = S_SERVE;
                end
                S_OVER, S_WIN: if (evt) m_state = S_IDLE;
                default: m_state = S_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("state",       32'(state),       m_state);
            check("ball_hold",   32'(ball_hold),   32'(m_state != S_PLAY));
            check("ball_run",    32'(ball_run),    32'(m_state == S_PLAY));
            check("bar_run",     32'(bar_run),     32'(m_state == S_SERVE || m_state == S_PLAY));
            check("lives",       32'(lives),       m_lives);
            check("score",       32'(score),       m_score);
            check("bricks_left", 32'(bricks_left), m_bricks);
            check("game_over",   32'(game_over),   32'(m_state == S_OVER));
            check("win",         32'(win),         32'(m_state == S_WIN));
        end
    end

    // The state code must never show an illegal value, even across reset.
    always @(state) begin
        if (cmp_en) check("state_legal", 32'(state > 3'd5), 0);
    end

    // One cycle of stimulus: pulses for the next rising edge, then back to 0.
    task automatic cyc(input bit bh, input bit bl, input bit ft);
        brick_hit  = bh;
        ball_lost  = bl;
        frame_tick = ft;
        @(negedge clock);
        brick_hit  = 1'b0;
        ball_lost  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic press(input int hold);
        start = 1'b0;
        repeat (hold) cyc(0, 0, 0);
        start = 1'b1;
        repeat (4) cyc(0, 0, 0);
    endtask

    task automatic lose_and_serve();
        cyc(0, 1, 0);
        repeat (LOST_FRAMES) cyc(0, 0, 1);
        press(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle state.
        repeat (3) @(negedge clock);
        cmp_en = 1'b1;
        reset  = 1'b1;
        repeat (2) cyc(0, 0, 0);
        check("rst_state", 32'(state), S_IDLE);
        check("rst_lives", 32'(lives), 3);
        check("rst_bricks", 32'(bricks_left), 40);
        check("rst_hold", 32'(ball_hold), 1);

        // Start latency: change at the second edge after the first low sample.
        start = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("lat_k1", 32'(state), S_IDLE);
        cyc(0, 0, 0);
        check("lat_k2", 32'(state), S_SERVE);
        check("lat_bar", 32'(bar_run), 1);
        repeat (7) cyc(0, 0, 0);
        start = 1'b1;
        repeat (4) cyc(0, 0, 0);
        check("serve_hold", 32'(state), S_SERVE);

        // Long hold gives exactly one transition.
        press(1000);
        check("play_state", 32'(state), S_PLAY);
        check("play_run", 32'(ball_run), 1);

        // Back-to-back brick hits.
        cyc(1, 0, 0);
        check("hit1_score", 32'(score), 7);
        cyc(1, 0, 0);
        check("hit2_score", 32'(score), 14);
        cyc(1, 0, 0);
        check("hit3_score", 32'(score), 21);
        check("hit3_bricks", 32'(bricks_left), 37);

        // Life lost; a frame_tick on the entry cycle is not counted.
        cyc(0, 1, 1);
        check("lost_state", 32'(state), S_LOST);
        check("lost_lives", 32'(lives), 2);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        press(3);
        check("lost_ignore_score", 32'(score), 21);
        check("lost_ignore_lives", 32'(lives), 2);
        check("lost_ignore_state", 32'(state), S_LOST);
        repeat (LOST_FRAMES - 1) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        check("lost_59", 32'(state), S_LOST);
        cyc(0, 0, 1);
        check("lost_60", 32'(state), S_SERVE);
        cyc(0, 0, 1);

        // Game over after the remaining lives go.
        press(3);
        lose_and_serve();
        cyc(0, 1, 0);
        check("over_state", 32'(state), S_OVER);
        check("over_flag", 32'(game_over), 1);
        check("over_lives", 32'(lives), 0);
        press(3);
        check("over_idle", 32'(state), S_IDLE);
        check("over_score_held", 32'(score), 21);
        press(3);
        check("reload_state", 32'(state), S_SERVE);
        check("reload_lives", 32'(lives), 3);
        check("reload_score", 32'(score), 0);
        check("reload_bricks", 32'(bricks_left), 40);

        // Saturation and a simultaneous last-brick / last-life win.
        press(3);
        repeat (36) cyc(1, 0, 0);
        check("sat_pre", 32'(score), 252);
        cyc(1, 0, 0);
        check("sat_hit", 32'(score), 255);
        repeat (2) cyc(1, 0, 0);
        check("sat_bricks", 32'(bricks_left), 1);
        lose_and_serve();
        lose_and_serve();
        cyc(1, 1, 0);
        check("both_win_state", 32'(state), S_WIN);
        check("both_win_lives", 32'(lives), 0);
        check("both_win_bricks", 32'(bricks_left), 0);
        check("both_win_flag", 32'(win), 1);
        cyc(1, 1, 0);

        // Simultaneous events with bricks to spare: ball_lost decides.
        press(3);
        press(3);
        press(3);
        lose_and_serve();
        lose_and_serve();
        repeat (35) cyc(1, 0, 0);
        check("pre5_bricks", 32'(bricks_left), 5);
        cyc(1, 1, 0);
        check("both_over_state", 32'(state), S_OVER);
        check("both_over_bricks", 32'(bricks_left), 4);
        check("both_over_score", 32'(score), 252);

        // Asynchronous reset between edges in the middle of play.
        press(3);
        press(3);
        press(3);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("arst_state", 32'(state), S_IDLE);
        check("arst_lives", 32'(lives), 3);
        check("arst_score", 32'(score), 0);
        check("arst_bricks", 32'(bricks_left), 40);
        check("arst_hold", 32'(ball_hold), 1);
        check("arst_run", 32'(ball_run), 0);
        check("arst_bar", 32'(bar_run), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) cyc(0, 0, 0);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
